// File: rtl/vend_pkg.sv
// Shared constants for the vending key front end.
// Channel index order doubles as release priority.
package vend_pkg;

  localparam int NUM_KEYS         = 5;
  localparam int KEY_N            = 0;
  localparam int KEY_D            = 1;
  localparam int KEY_ITEM1        = 2;
  localparam int KEY_ITEM2        = 3;
  localparam int KEY_PUSH         = 4;
  localparam int DEBOUNCE_DEFAULT = 250000;

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchroniser, debounce counter,
// combinational pulse on the edge the debounced level rises.
module key_debounce
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic [CNT_W-1:0] r_cnt;
  logic             w_flip;

  assign w_flip = (r_sync2 != r_deb) && (r_cnt == CNT_LAST);
  assign o_rise = w_flip & r_sync2;

  // Synchronise, then flip the debounced level after a stable run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vend_key_conditioner.sv
// Vending key conditioner: five debounced keys, one pulse per clock.
// Define VEND_KEY_STATS_EN to enable nickel/dime counters.
module vend_key_conditioner
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       n_raw,
  input  logic       d_raw,
  input  logic       item1_raw,
  input  logic       item2_raw,
  input  logic       push_raw,
  output logic       N,
  output logic       D,
  output logic       item1,
  output logic       item2,
  output logic       push,
  output logic       busy,
  output logic [7:0] nickel_cnt,
  output logic [7:0] dime_cnt
);

  logic [NUM_KEYS-1:0] w_raw;
  logic [NUM_KEYS-1:0] w_rise;
  logic [NUM_KEYS-1:0] w_grant;
  logic [NUM_KEYS-1:0] w_pend_nxt;
  logic [NUM_KEYS-1:0] r_pend;
  logic [NUM_KEYS-1:0] r_out;
  logic                r_busy;

  assign w_raw[KEY_N]     = n_raw;
  assign w_raw[KEY_D]     = d_raw;
  assign w_raw[KEY_ITEM1] = item1_raw;
  assign w_raw[KEY_ITEM2] = item2_raw;
  assign w_raw[KEY_PUSH]  = push_raw;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_raw  (w_raw[g]),
      .o_rise (w_rise[g])
    );
  end

  // Lowest index wins; a rise on the granted bit keeps it pending
  assign w_grant    = r_pend & (~r_pend + 1'b1);
  assign w_pend_nxt = (r_pend & ~w_grant) | w_rise;

  // Pending flags, one-hot output pulse and busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_out  <= '0;
      r_busy <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_out  <= w_grant;
      r_busy <= |w_pend_nxt;
    end
  end

  assign N     = r_out[KEY_N];
  assign D     = r_out[KEY_D];
  assign item1 = r_out[KEY_ITEM1];
  assign item2 = r_out[KEY_ITEM2];
  assign push  = r_out[KEY_PUSH];
  assign busy  = r_busy;

`ifdef VEND_KEY_STATS_EN
  logic [7:0] r_ncnt;
  logic [7:0] r_dcnt;

  // Saturating coin counters, bumped with each released coin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ncnt <= '0;
      r_dcnt <= '0;
    end else begin
      if (w_grant[KEY_N] && r_ncnt != 8'hFF)
        r_ncnt <= r_ncnt + 8'd1;
      if (w_grant[KEY_D] && r_dcnt != 8'hFF)
        r_dcnt <= r_dcnt + 8'd1;
    end
  end

  assign nickel_cnt = r_ncnt;
  assign dime_cnt   = r_dcnt;
`else
  assign nickel_cnt = 8'd0;
  assign dime_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_vend_key_conditioner.sv
// Directed bench for vend_key_conditioner with DEBOUNCE_CYCLES=4.
// Define VEND_KEY_STATS_EN to check the coin counters.
module tb_vend_key_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       n_raw, d_raw, item1_raw, item2_raw, push_raw;
  logic       N, D, item1, item2, push, busy;
  logic [7:0] nickel_cnt, dime_cnt;

  int nerr = 0;
  int nchk = 0;
  int edge_n = 0;
  int pcnt [5];
  int plast [5];
  int pbusy [5];
  int multi = 0;
  int base [5];
  int e;

  vend_key_conditioner #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .n_raw      (n_raw),
    .d_raw      (d_raw),
    .item1_raw  (item1_raw),
    .item2_raw  (item2_raw),
    .push_raw   (push_raw),
    .N          (N),
    .D          (D),
    .item1      (item1),
    .item2      (item2),
    .push       (push),
    .busy       (busy),
    .nickel_cnt (nickel_cnt),
    .dime_cnt   (dime_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n++;

  // Pulse monitor: counts, edge of last pulse, busy seen with it
  always @(negedge clk) begin
    logic [4:0] v;
    v = {push, item2, item1, D, N};
    if ($countones(v) > 1) multi++;
    for (int i = 0; i < 5; i++) begin
      if (v[i]) begin
        pcnt[i]++;
        plast[i] = edge_n;
        pbusy[i] = int'(busy);
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < 5; i++) base[i] = pcnt[i];
  endtask

  task automatic press_n();
    n_raw = 1'b1;
    step(8);
    n_raw = 1'b0;
    step(8);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      pcnt[i] = 0;
      plast[i] = -1;
      pbusy[i] = -1;
    end
    rst_n = 1'b0;
    n_raw = 1'b1;
    d_raw = 1'b0;
    item1_raw = 1'b0;
    item2_raw = 1'b0;
    push_raw = 1'b0;

    // Reset held with n_raw high
    step(3);
    @(negedge clk);
    chk("rst_outs", int'({push, item2, item1, D, N}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ncnt", int'(nickel_cnt), 0);
    snap();
    step(1);
    rst_n = 1'b1;
    e = edge_n;
    step(20);
    chk("rst_n_pulses", pcnt[0] - base[0], 1);
    chk("rst_n_edge", plast[0], e + 7);
    chk("rst_n_busy", pbusy[0], 0);
    n_raw = 1'b0;
    step(15);
    chk("rst_n_hold", pcnt[0] - base[0], 1);

    // Bounce on dime
    snap();
    d_raw = 1'b1; step(2);
    d_raw = 1'b0; step(2);
    d_raw = 1'b1; step(2);
    d_raw = 1'b0; step(2);
    d_raw = 1'b1;
    e = edge_n;
    step(20);
    chk("bnc_d_pulses", pcnt[1] - base[1], 1);
    chk("bnc_d_edge", plast[1], e + 7);
    d_raw = 1'b0;
    step(15);
    chk("bnc_d_rel", pcnt[1] - base[1], 1);

    // Simultaneous N, item2, push
    snap();
    n_raw = 1'b1;
    item2_raw = 1'b1;
    push_raw = 1'b1;
    e = edge_n;
    step(20);
    chk("sim_n_edge", plast[0], e + 7);
    chk("sim_i2_edge", plast[3], e + 8);
    chk("sim_p_edge", plast[4], e + 9);
    chk("sim_n_busy", pbusy[0], 1);
    chk("sim_i2_busy", pbusy[3], 1);
    chk("sim_p_busy", pbusy[4], 0);
    chk("sim_n_cnt", pcnt[0] - base[0], 1);
    chk("sim_p_cnt", pcnt[4] - base[4], 1);
    n_raw = 1'b0;
    item2_raw = 1'b0;
    push_raw = 1'b0;
    step(15);

    // Release generates nothing
    snap();
    item1_raw = 1'b1;
    step(20);
    item1_raw = 1'b0;
    step(20);
    chk("rel_i1_cnt", pcnt[2] - base[2], 1);

    // Reset while three events pending
    snap();
    n_raw = 1'b1;
    d_raw = 1'b1;
    item1_raw = 1'b1;
    step(6);
    @(negedge clk);
    chk("mid_busy_pre", int'(busy), 1);
    #1;
    rst_n = 1'b0;
    n_raw = 1'b0;
    d_raw = 1'b0;
    item1_raw = 1'b0;
    #1;
    chk("mid_busy_rst", int'(busy), 0);
    step(3);
    rst_n = 1'b1;
    step(25);
    chk("mid_n_cnt", pcnt[0] - base[0], 0);
    chk("mid_d_cnt", pcnt[1] - base[1], 0);
    chk("mid_i1_cnt", pcnt[2] - base[2], 0);

    // Stats: nickel presses
    snap();
    for (int i = 0; i < 3; i++) press_n();
`ifdef VEND_KEY_STATS_EN
    chk("st_ncnt3", int'(nickel_cnt), 3);
`else
    chk("st_ncnt3", int'(nickel_cnt), 0);
`endif
    for (int i = 3; i < 255; i++) press_n();
`ifdef VEND_KEY_STATS_EN
    chk("st_ncnt255", int'(nickel_cnt), 255);
`else
    chk("st_ncnt255", int'(nickel_cnt), 0);
`endif
    for (int i = 255; i < 260; i++) press_n();
    chk("st_pulses", pcnt[0] - base[0], 260);
`ifdef VEND_KEY_STATS_EN
    chk("st_ncnt_sat", int'(nickel_cnt), 255);
`else
    chk("st_ncnt_sat", int'(nickel_cnt), 0);
`endif
    chk("st_dcnt", int'(dime_cnt), 0);
    chk("one_hot", multi, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/vend_key_conditioner.md
Name: vend_key_conditioner

Overview:
- Front end of the vending controller. Conditions five raw mechanical inputs (nickel slot, dime slot, item1, item2, push) into clean single-cycle pulses N, D, item1, item2, push.
- Pulses feed the downstream vending state machine, which expects at most one event per clock.
- Per-channel processing: synchronise, debounce, detect the rising edge, then buffer pending events and release them one per cycle in fixed priority.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive clk cycles a synchronised input must differ from its debounced state before that state flips. Default is 5 ms at 50 MHz. Legal range 1..2^20.
- CNT_W, localparam $clog2(DEBOUNCE_CYCLES+1), debounce counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- n_raw  in  1  nickel switch, active-high, asynchronous to clk.
- d_raw  in  1  dime switch, active-high, asynchronous.
- item1_raw  in  1  item1 button, active-high, asynchronous.
- item2_raw  in  1  item2 button, active-high, asynchronous.
- push_raw  in  1  cancel/return button, active-high, asynchronous.
- N  out  1  registered one-cycle nickel event.
- D  out  1  registered one-cycle dime event.
- item1  out  1  registered one-cycle item1 event.
- item2  out  1  registered one-cycle item2 event.
- push  out  1  registered one-cycle push event.
- busy  out  1  registered; 1 while any event is pending release.
- nickel_cnt  out  8  accepted-nickel count (optional feature).
- dime_cnt  out  8  accepted-dime count (optional feature).

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). While rst_n=0, the following are all 0: sync flops, debounced states, debounce counters, pending flags, all outputs, both counters.
- Synchroniser: 2-flop per channel. sync2 is the debounce input.
- Debounce per channel:
  - If sync2==deb, cnt<=0.
  - Else, if cnt==DEBOUNCE_CYCLES-1, then deb<=sync2 and cnt<=0; otherwise cnt<=cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Rise detect: on the edge where deb goes 0->1, pending[ch]<=1. Release (1->0) generates nothing.
- Release arbiter:
  - Each edge, the highest-priority set pending bit drives its output high for exactly one cycle, and that bit clears.
  - Priority: N > D > item1 > item2 > push.
  - All other outputs are 0 that cycle; at most one output is high in any cycle.
- Simultaneous set and clear: a new rise on a channel at the same edge its pending bit is released leaves pending=1, giving a second pulse later. A rise while already pending is merged (one pulse).
- Latency: raw level first sampled at edge k gives the output pulse high during the cycle after edge k+DEBOUNCE_CYCLES+2, provided no higher-priority event is pending. Each higher pending event adds one cycle.
- busy = |pending, registered alongside the outputs.
- Reset mid-operation: pending events are discarded and counters restart. A button still held after reset deasserts generates a new pulse after the debounce interval.

Optional Feature:
- Macro VEND_KEY_STATS_EN.
- Defined: nickel_cnt and dime_cnt increment on each N or D output pulse. They saturate at 255 and clear only on reset.
- Undefined: both ports are present but tied to 8'd0, and no counter logic is synthesised.

Decomposition:
- Package vend_pkg:
  - NUM_KEYS=5.
  - Channel index constants KEY_N=0, KEY_D=1, KEY_ITEM1=2, KEY_ITEM2=3, KEY_PUSH=4. Index order is priority order.
  - Default DEBOUNCE_CYCLES value.
- Sub-module key_debounce: synchroniser + debounce counter + rise-pulse output. Instantiated NUM_KEYS times.
- Arbiter and stats logic stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset behaviour: hold n_raw=1 while rst_n=0 -> all outputs 0 and busy=0. Release rst_n -> single N pulse 6 edges later, then no further pulse while n_raw stays high.
- Bounce: d_raw toggles 1,0,1,0 every 2 cycles, then holds 1 -> exactly one D pulse, 6 edges after the final 0->1 sample. No pulse from the 2-cycle glitches.
- Simultaneous: n_raw, item2_raw and push_raw rise on the same edge -> N, item2, push pulses on three consecutive cycles in that order. busy=1 through the first two of those cycles and 0 after push.
- Release ignored: item1_raw held 20 cycles, then dropped -> exactly one item1 pulse, none on release.
- Reset mid-operation: assert rst_n=0 while 3 events are pending -> no pulses, busy=0. Raw lines low on reset release -> no pulses afterwards.
- Stats (VEND_KEY_STATS_EN): 260 clean nickel presses -> nickel_cnt=255 (saturated), dime_cnt=0. Without the macro, both read 0.
